sync_fifo_ptr_ctrl: RTL
=======================

// Module: sync_fifo_ptr_ctrl
// PURPOSE
//  Single-clock FIFO pointer and flag controller for arbitrary (non-power-of-2) DEPTH.
//  Owns both write and read pointers (wrap bit + address) and produces RAM addresses,
//  full/empty, almost-full/almost-empty and occupancy count.
//  Sits between producer/consumer handshakes and a DEPTH-entry simple dual-port RAM.
//  Successor of the single-sided read-pointer block; adds write side, thresholds and count.
// PARAMETERS
//  ADDR_W     7   address bits; pointers are ADDR_W+1 wide (MSB = wrap bit); DEPTH <= 2**ADDR_W
//  DEPTH      90  number of FIFO entries, 2..2**ADDR_W
//  AF_MARGIN  4   almost_full asserts when count >= DEPTH-AF_MARGIN
//  AE_MARGIN  4   almost_empty asserts when count <= AE_MARGIN
// PORTS
//  clk           in   1         single clock, all logic on posedge
//  rst           in   1         synchronous, active-high reset
//  wr_en         in   1         write request
//  rd_en         in   1         read request
//  wr_accept     out  1         wr_en && !full (comb); RAM write strobe
//  rd_accept     out  1         rd_en && !empty (comb); RAM read strobe
//  wr_addr       out  ADDR_W    RAM write address = wr_ptr[ADDR_W-1:0]
//  rd_addr       out  ADDR_W    RAM read address = rd_ptr[ADDR_W-1:0]
//  wr_ptr        out  ADDR_W+1  registered write pointer incl. wrap bit
//  rd_ptr        out  ADDR_W+1  registered read pointer incl. wrap bit
//  count         out  ADDR_W+1  registered occupancy, 0..DEPTH
//  fifo_full     out  1         wrap bits differ, addresses equal
//  fifo_empty    out  1         pointers fully equal
//  almost_full   out  1         count >= DEPTH-AF_MARGIN
//  almost_empty  out  1         count <= AE_MARGIN
//  overflow      out  1         only with FIFO_PTR_ERR_EN: sticky, wr_en while full
//  underflow     out  1         only with FIFO_PTR_ERR_EN: sticky, rd_en while empty
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): wr_ptr=0, rd_ptr=0, count=0, overflow=underflow=0;
//    hence fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0. Reset wins over wr/rd.
//  - Flags are pure decode of registered pointers/count: valid same cycle as state,
//    no extra latency. Accepted op updates pointers/count at the next posedge.
//  - Pointer advance: address+1 while address < DEPTH-1; at DEPTH-1 address -> 0 and
//    wrap bit toggles. Addresses DEPTH..2**ADDR_W-1 never produced.
//  - Write blocked when fifo_full regardless of rd_en; read blocked when fifo_empty
//    regardless of wr_en (no write-through, no same-cycle fill-then-free credit).
//  - count: +1 on wr_accept only, -1 on rd_accept only, unchanged on both or neither.
//    count never exceeds DEPTH nor goes below 0.
//  - Rejected requests change no state except the sticky error bits (if compiled).
//  - Reset mid-operation discards contents; no partial pointer state retained.
// CONFIGURATION
//  FIFO_PTR_ERR_EN defined: overflow/underflow ports exist; set on wr_en&&fifo_full /
//    rd_en&&fifo_empty, hold until rst.
//  FIFO_PTR_ERR_EN undefined: ports and logic absent; rejected requests silently dropped.
// TESTING  (defaults ADDR_W=7, DEPTH=90, margins 4)
//  1 rst=1 one cycle -> ptrs=0, count=0, empty=1, almost_empty=1, full=0.
//  2 90 back-to-back writes -> count=90, full=1, wr_ptr=8'h80; almost_full from count=86;
//    91st write: wr_accept=0, ptr unchanged, overflow=1 (if compiled).
//  3 from full, 90 reads -> empty=1, rd_ptr=8'h80; extra read: rd_accept=0, underflow=1.
//  4 at count=45 assert wr_en&rd_en 10 cycles -> count stays 45, both ptrs +10.
//  5 at full assert wr_en&rd_en -> only read accepted, count=89; at empty -> only write, count=1.
//  6 200 continuous wr/rd (1 entry lag), then rst mid-stream -> addresses wrap 89->0
//    twice, wrap bit toggles twice; after rst state equals scenario 1.

Source files
------------

// File: rtl/sync_fifo_ptr_ctrl.sv
// rtl/sync_fifo_ptr_ctrl.sv - single-clock FIFO pointer/flag controller for arbitrary DEPTH
// Optional FIFO_PTR_ERR_EN adds sticky overflow/underflow outputs.
module sync_fifo_ptr_ctrl #(
   parameter int ADDR_W    = 7,
   parameter int DEPTH     = 90,
   parameter int AF_MARGIN = 4,
   parameter int AE_MARGIN = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic              rd_en,
   output logic              wr_accept,
   output logic              rd_accept,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [ADDR_W:0]   wr_ptr,
   output logic [ADDR_W:0]   rd_ptr,
   output logic [ADDR_W:0]   count,
   output logic              fifo_full,
   output logic              fifo_empty,
   output logic              almost_full,
`ifdef FIFO_PTR_ERR_EN
   output logic              overflow,
   output logic              underflow,
`endif
   output logic              almost_empty
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   AF_LEVEL  = (ADDR_W+1)'(DEPTH - AF_MARGIN);
   localparam logic [ADDR_W:0]   AE_LEVEL  = (ADDR_W+1)'(AE_MARGIN);

   logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0] count_q, count_d;

   // Address wraps at DEPTH-1 rather than at the power-of-two boundary.
   function automatic logic [ADDR_W:0] ptr_inc(input logic [ADDR_W:0] p);
      if (p[ADDR_W-1:0] == LAST_ADDR) begin
         ptr_inc = {~p[ADDR_W], {ADDR_W{1'b0}}};
      end else begin
         ptr_inc = p + (ADDR_W+1)'(1);
      end
   endfunction

   assign fifo_full    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                         (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
   assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
   assign almost_full  = (count_q >= AF_LEVEL);
   assign almost_empty = (count_q <= AE_LEVEL);
   assign wr_accept    = wr_en && !fifo_full;
   assign rd_accept    = rd_en && !fifo_empty;
   assign wr_ptr       = wr_ptr_q;
   assign rd_ptr       = rd_ptr_q;
   assign wr_addr      = wr_ptr_q[ADDR_W-1:0];
   assign rd_addr      = rd_ptr_q[ADDR_W-1:0];
   assign count        = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_accept) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_accept) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({wr_accept, rd_accept})
         2'b10:   count_d = count_q + (ADDR_W+1)'(1);
         2'b01:   count_d = count_q - (ADDR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

`ifdef FIFO_PTR_ERR_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   always_comb begin
      overflow_d  = overflow_q || (wr_en && fifo_full);
      underflow_d = underflow_q || (rd_en && fifo_empty);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`endif

endmodule
